// File: rtl/keypad_event_ctrl_if.sv
// Event stream between keypad_event_ctrl (master) and its consumer (slave).
interface keypad_event_ctrl_if;
  logic       evt_ready;
  logic       evt_valid;
  logic [4:0] evt_code;
  logic       evt_press;
  logic       evt_repeat;
  logic [2:0] evt_count;
  logic       overflow;

  modport master (
    input  evt_ready,
    output evt_valid, evt_code, evt_press, evt_repeat, evt_count, overflow
  );

  modport slave (
    output evt_ready,
    input  evt_valid, evt_code, evt_press, evt_repeat, evt_count, overflow
  );
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad press/release debouncer with a 4-deep show-ahead event FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//
// state   | meaning
// IDLE    | no key tracked, waiting for a scan hit
// CONFIRM | counting matching hits before reporting a press
// HELD    | press reported, waiting for RELEASE_TIMEOUT silent cycles
module keypad_event_ctrl #(
  parameter int CONFIRM_HITS    = 4,
  parameter int RELEASE_TIMEOUT = 1000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [24:0]                btn,
  keypad_event_ctrl_if.master        evt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  localparam logic [7:0]  HITS_TC = 8'(CONFIRM_HITS);
  localparam logic [15:0] MISS_TC = 16'(RELEASE_TIMEOUT);

  logic [1:0]  state, state_n;
  logic [7:0]  hits, hits_n;
  logic [15:0] miss, miss_n;
  logic [4:0]  held_code, code_n;
  logic [4:0]  hit_code;
  logic        hit, same, rpt_tick;
  logic        push;
  logic [6:0]  push_data;   // {repeat, press, code}

  always_comb begin
    hit_code = '0;
    for (int i = 24; i >= 0; i--)
      if (btn[i]) hit_code = 5'(i);
  end

  assign hit  = |btn;
  assign same = hit && (hit_code == held_code);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [25:0] RPT_TC = 26'(REPEAT_PERIOD);
  logic [25:0] rpt;

  assign rpt_tick = (state == S_HELD) && (rpt + 26'd1 == RPT_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rpt <= '0;
    else if (state != S_HELD)  rpt <= '0;
    else if (rpt_tick)         rpt <= '0;
    else                       rpt <= rpt + 26'd1;
  end
`else
  assign rpt_tick = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    hits_n    = hits;
    miss_n    = miss;
    code_n    = held_code;
    push      = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          code_n = hit_code;
          hits_n = 8'd1;
          miss_n = '0;
          if (HITS_TC == 8'd1) begin
            push      = 1'b1;
            push_data = {2'b01, hit_code};
            state_n   = S_HELD;
          end else begin
            state_n = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        if (same) begin
          hits_n = hits + 8'd1;
          miss_n = '0;
          if (hits + 8'd1 == HITS_TC) begin
            push      = 1'b1;
            push_data = {2'b01, held_code};
            state_n   = S_HELD;
          end
        end else if (hit) begin
          state_n = S_IDLE;
        end else begin
          miss_n = miss + 16'd1;
          if (miss + 16'd1 == MISS_TC) state_n = S_IDLE;
        end
      end
      S_HELD: begin
        // A different key while held counts as silence.
        miss_n = same ? '0 : miss + 16'd1;
        if (!same && (miss + 16'd1 == MISS_TC)) begin
          push      = 1'b1;
          push_data = {2'b00, held_code};
          state_n   = S_IDLE;
        end else if (rpt_tick) begin
          push      = 1'b1;
          push_data = {2'b11, held_code};
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hits      <= '0;
      miss      <= '0;
      held_code <= '0;
    end else begin
      state     <= state_n;
      hits      <= hits_n;
      miss      <= miss_n;
      held_code <= code_n;
    end
  end

  logic [6:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       ovf, pop, full, do_push;
  logic [6:0] head;

  assign full    = (count == 3'd4);
  assign pop     = evt.evt_valid && evt.evt_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign evt.evt_valid = (count != 3'd0);
  assign evt.evt_count = count;
  assign evt.overflow  = ovf;
  assign evt.evt_code  = evt.evt_valid ? head[4:0] : 5'd0;
  assign evt.evt_press = evt.evt_valid & head[5];

`ifdef KEYPAD_REPEAT_EN
  assign evt.evt_repeat = evt.evt_valid & head[6];
`else
  logic unused_cfg;
  assign unused_cfg     = ^{26'(REPEAT_PERIOD), head[6]};
  assign evt.evt_repeat = 1'b0;
`endif

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 Parameter: CONFIRM_HITS, default 4, number of matching scan hits to confirm a press (range 1..255).
REQ-002 Parameter: RELEASE_TIMEOUT, default 1000, consecutive silent cycles (btn==0) that end a press (range 2..65535).
REQ-003 Parameter: REPEAT_PERIOD, default 25000000, cycles between auto-repeat events while held (range 2..2^26-1).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 btn  input  25  scan result from the 5x5 keypad scanner; bit i set = key i seen this cycle, zero otherwise.
REQ-007 evt_ready  input  1  consumer accepts the head event this cycle.
REQ-008 evt_valid  output  1  event FIFO non-empty.
REQ-009 evt_code  output  5  key index 0..24 of the head event.
REQ-010 evt_press  output  1  head event type: 1 = press, 0 = release.
REQ-011 evt_repeat  output  1  head event is an auto-repeat press.
REQ-012 evt_count  output  3  FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky: at least one event dropped because the FIFO was full.

Function
REQ-014 Key encode: the block SHALL use the lowest set bit index of btn as the key code; btn==0 means no hit.
REQ-015 FSM states: IDLE, CONFIRM, HELD; a hit counter (8 bit), a miss counter (16 bit), a repeat counter (26 bit), and a held code register (5 bit).
REQ-016 IDLE: btn!=0 -> capture code, hits=1, miss=0, go CONFIRM; if CONFIRM_HITS==1, push press and go HELD instead.
REQ-017 CONFIRM: hit with same code -> hits+1, miss=0; when hits reaches CONFIRM_HITS, push press {repeat=0}, repeat counter=0, go HELD.
REQ-018 CONFIRM: hit with different code -> go IDLE, no event; btn==0 -> miss+1; miss reaching RELEASE_TIMEOUT -> go IDLE, no event.
REQ-019 HELD: hit with same code -> miss=0; hit with different code is ignored (counts as silence); silence -> miss+1.
REQ-020 HELD: miss reaching RELEASE_TIMEOUT -> push release {press=0, repeat=0} with held code, go IDLE.
REQ-021 FIFO: 4 entries of {repeat, press, code}; show-ahead head on evt_*; evt_valid = (evt_count!=0).
REQ-022 Pop occurs when evt_valid and evt_ready in the same cycle; evt_ready while empty has no effect.
REQ-023 Latency: a push in cycle N SHALL appear at evt_valid/evt_count in cycle N+1 when the FIFO was empty.
REQ-024 Push while full with no pop: event dropped, evt_count stays 4, overflow set; push and pop in the same cycle while full: both succeed, count stays 4.
REQ-025 Simultaneous push and pop at any other occupancy: count unchanged, order preserved (FIFO order strict).
REQ-026 Release event SHALL be pushed even if the release coincides with a repeat tick; the release wins, the repeat is suppressed.

Reset
REQ-027 rst asserted: state=IDLE, all counters 0, FIFO emptied, evt_valid=0, evt_code=0, evt_press=0, evt_repeat=0, evt_count=0, overflow=0, immediately (asynchronous).
REQ-028 rst during CONFIRM or HELD SHALL discard the in-progress key with no release event after deassertion.

Configuration
REQ-029 Macro KEYPAD_REPEAT_EN defined: in HELD the repeat counter increments each cycle; on reaching REPEAT_PERIOD it pushes press {repeat=1} with held code and restarts at 0.
REQ-030 Macro KEYPAD_REPEAT_EN undefined: no repeat counter logic; evt_repeat SHALL be constant 0 and HELD produces only the release event.

Verification (CONFIRM_HITS=2, RELEASE_TIMEOUT=8, REPEAT_PERIOD=20)
REQ-031 btn=bit 7 for 2 cycles, then 0 for 8 cycles, evt_ready=1 -> press code 7, then release code 7; evt_count never exceeds 1.
REQ-032 btn=bit 3 for 1 cycle, then bit 9 -> no press for 3; CONFIRM restarts; bit 9 confirmed after 2 more hits -> press code 9.
REQ-033 btn=bits 4 and 12 together, held -> events carry code 4 only.
REQ-034 evt_ready=0, five press/release cycles of key 1 -> first 4 events kept, evt_count=4, overflow=1; drain -> order press,release,press,release.
REQ-035 With KEYPAD_REPEAT_EN, key 20 held 50 cycles -> press, repeat press at +20 and +40 cycles (evt_repeat=1), then release; without macro -> press, release only.
REQ-036 rst pulsed mid-HELD with 2 events queued -> outputs 0 within the reset cycle; no release event afterwards.
